// File: rtl/ahb_uart_fifo_pkg.sv
// rtl/ahb_uart_fifo_pkg.sv - register map, bit positions and TX FSM encoding for ahb_uart_fifo
package ahb_uart_fifo_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CMD    = 2'd3;

    localparam int ST_TX_FULL     = 0;
    localparam int ST_TX_EMPTY    = 1;
    localparam int ST_RX_FULL     = 2;
    localparam int ST_RX_EMPTY    = 3;
    localparam int ST_RX_OVERRUN  = 4;
    localparam int ST_TX_OVERFLOW = 5;
    localparam int ST_TX_COUNT    = 8;
    localparam int ST_RX_COUNT    = 16;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    localparam int CMD_CLR_FLAGS = 0;
    localparam int CMD_FLUSH_TX  = 1;
    localparam int CMD_FLUSH_RX  = 2;

    typedef logic [1:0] tx_state_t;
    localparam tx_state_t TX_IDLE      = 2'd0;
    localparam tx_state_t TX_LAUNCH    = 2'd1;
    localparam tx_state_t TX_WAIT_BUSY = 2'd2;
    localparam tx_state_t TX_WAIT_DONE = 2'd3;

    // A 256-deep FIFO holds 256 entries, which does not fit the 8-bit STATUS field.
    function automatic logic [7:0] sat_count8(input logic [31:0] cnt);
        return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/ahb_uart_fifo_if.sv
// rtl/ahb_uart_fifo_if.sv - AHB-Lite slave port bundle for ahb_uart_fifo
interface ahb_uart_fifo_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_uart_fifo_sync_fifo.sv
// rtl/ahb_uart_fifo_sync_fifo.sv - show-ahead synchronous FIFO with flush and occupancy count
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ahb_uart_fifo.sv
// rtl/ahb_uart_fifo.sv - buffered AHB-Lite UART slave: TX/RX FIFOs, TX drain FSM, level IRQ
module ahb_uart_fifo
    import ahb_uart_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_uart_fifo_if.slave bus,
    output logic [7:0]     TX_DATA,
    output logic           TX_EN,
    input  logic           TX_BUSY,
    input  logic [7:0]     RX_DATA,
    input  logic           RX_VALID,
    output logic           IRQ
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          dp_valid;
    logic          dp_write;
    logic [1:0]    dp_addr;
    logic          accept;
    logic          wr_data, rd_data, wr_ctrl, wr_cmd, rd_any;
    logic          cmd_clr, flush_tx, flush_rx;
    logic          tx_pop, tx_full, tx_empty;
    logic          rx_pop, rx_full, rx_empty;
    logic [7:0]    tx_head, rx_head;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_overflow, rx_overrun;
    logic [1:0]    ctrl;
    logic [31:0]   status;
    logic [31:0]   rdata;
    tx_state_t     state;
    logic          unused_bits;

    assign unused_bits = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0],
                           bus.HTRANS[0], bus.HWDATA[31:8]};

    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 2'd0;
        end else if (bus.HREADY) begin
            dp_valid <= accept;
            dp_write <= bus.HWRITE;
            dp_addr  <= bus.HADDR[3:2];
        end
    end

    assign wr_data = dp_valid &  dp_write & (dp_addr == ADDR_DATA);
    assign rd_data = dp_valid & ~dp_write & (dp_addr == ADDR_DATA);
    assign wr_ctrl = dp_valid &  dp_write & (dp_addr == ADDR_CTRL);
    assign wr_cmd  = dp_valid &  dp_write & (dp_addr == ADDR_CMD);
    assign rd_any  = dp_valid & ~dp_write;

    assign cmd_clr  = wr_cmd & bus.HWDATA[CMD_CLR_FLAGS];
    assign flush_tx = wr_cmd & bus.HWDATA[CMD_FLUSH_TX];
    assign flush_rx = wr_cmd & bus.HWDATA[CMD_FLUSH_RX];

    assign tx_pop = (state == TX_IDLE) & ~tx_empty;
    assign rx_pop = rd_data & ~rx_empty;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (wr_data),
        .pop   (tx_pop),
        .flush (flush_tx),
        .din   (bus.HWDATA[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (RX_VALID),
        .pop   (rx_pop),
        .flush (flush_rx),
        .din   (RX_DATA),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A new drop event outranks a clear arriving in the same cycle.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tx_overflow <= 1'b0;
            rx_overrun  <= 1'b0;
            ctrl        <= 2'd0;
        end else begin
            tx_overflow <= (wr_data & tx_full & ~tx_pop) | (tx_overflow & ~cmd_clr);
            rx_overrun  <= (RX_VALID & rx_full & ~rx_pop) | (rx_overrun & ~cmd_clr);
            if (wr_ctrl) ctrl <= bus.HWDATA[1:0];
        end
    end

    // The head is popped and captured on the IDLE->LAUNCH edge so TX_DATA is valid with TX_EN.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= TX_IDLE;
            TX_EN   <= 1'b0;
            TX_DATA <= 8'd0;
        end else begin
            TX_EN <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        state   <= TX_LAUNCH;
                        TX_EN   <= 1'b1;
                        TX_DATA <= tx_head;
                    end
                end
                TX_LAUNCH:    state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (TX_BUSY)  state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (!TX_BUSY) state <= TX_IDLE;
                default:      state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) IRQ <= 1'b0;
        else IRQ <= (ctrl[CTRL_RX_IRQ_EN] & ~rx_empty) |
                    (ctrl[CTRL_TX_IRQ_EN] & tx_empty & (state == TX_IDLE));
    end

    always_comb begin
        status                       = 32'd0;
        status[ST_TX_FULL]           = tx_full;
        status[ST_TX_EMPTY]          = tx_empty;
        status[ST_RX_FULL]           = rx_full;
        status[ST_RX_EMPTY]          = rx_empty;
        status[ST_RX_OVERRUN]        = rx_overrun;
        status[ST_TX_OVERFLOW]       = tx_overflow;
        status[ST_TX_COUNT +: 8]     = sat_count8(32'(tx_count));
        status[ST_RX_COUNT +: 8]     = sat_count8(32'(rx_count));
    end

    always_comb begin
        rdata = 32'd0;
        if (rd_any) begin
            case (dp_addr)
                ADDR_DATA:   rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
                ADDR_STATUS: rdata = status;
                ADDR_CTRL:   rdata = {30'd0, ctrl};
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign bus.HRDATA = rdata;
endmodule

// File: tb/tb_ahb_uart_fifo.sv
// tb/tb_ahb_uart_fifo.sv - self-checking bench for ahb_uart_fifo
module tb_ahb_uart_fifo;
    import ahb_uart_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic       HCLK;
    logic       HRESET;
    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_BUSY;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       IRQ;

    ahb_uart_fifo_if bus ();

    ahb_uart_fifo #(.DEPTH(DEPTH)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .bus      (bus),
        .TX_DATA  (TX_DATA),
        .TX_EN    (TX_EN),
        .TX_BUSY  (TX_BUSY),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .IRQ      (IRQ)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int umode    = 0;     // UART model: 0 = 10-cycle frames, 1 = busy held high
    int frame_cnt = 0;
    logic [7:0] launched_q [$];

    typedef struct {
        logic        wr;
        logic [1:0]  r;
        logic [31:0] data;
        logic        chk_irq;
        logic        exp_irq;
    } vec_t;
    vec_t vecs [9];

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // UART_TX stand-in: records every launch and models the busy window.
    initial begin
        TX_BUSY = 1'b0;
        forever begin
            @(posedge HCLK);
            #1;
            if (TX_EN === 1'b1) begin
                launched_q.push_back(TX_DATA);
                if (umode == 0) check("launch_after_busy_low", 32'(TX_BUSY), 32'd0);
                frame_cnt = 10;
            end else if (frame_cnt > 0) begin
                frame_cnt--;
            end
            TX_BUSY = (umode == 1) ? 1'b1 : (frame_cnt > 0);
        end
    end

    task automatic ahb_addr(input logic [1:0] r, input logic wr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HWRITE = wr;
        bus.HSIZE  = 3'($urandom_range(0, 2));
        bus.HADDR  = 32'h5000_0000 | {28'd0, r, 2'b00};
        tick();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 32'd0;
    endtask

    task automatic ahb_write(input logic [1:0] r, input logic [31:0] d);
        ahb_addr(r, 1'b1);
        bus.HWDATA = d;
        tick();
        bus.HWDATA = 32'd0;
    endtask

    task automatic ahb_read(input logic [1:0] r, input logic rxv, input logic [7:0] rxb,
                            output logic [31:0] d);
        ahb_addr(r, 1'b0);
        RX_VALID = rxv;
        RX_DATA  = rxb;
        d = bus.HRDATA;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        RX_VALID = 1'b1;
        RX_DATA  = b;
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget);
        for (int i = 0; i < budget && launched_q.size() < n; i++) tick();
        check("launch_count", 32'(launched_q.size()), 32'(n));
    endtask

    initial begin
        logic [31:0] d, d1, d2;
        logic [7:0]  rxm [$];
        logic [7:0]  txm [$];
        logic        m_ovr;
        logic [7:0]  b, ev;
        int          op;

        HRESET = 1'b1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HADDR = 32'd0;
        bus.HSIZE = 3'd2; bus.HPROT = 4'd3; bus.HWDATA = 32'd0; bus.HREADY = 1'b1;
        RX_VALID = 1'b0; RX_DATA = 8'd0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        tick();
        check("reset_hrdata", bus.HRDATA, 32'd0);
        check("reset_tx_en", 32'(TX_EN), 32'd0);
        check("reset_tx_data", 32'(TX_DATA), 32'd0);
        check("reset_irq", 32'(IRQ), 32'd0);
        check("hreadyout", 32'(bus.HREADYOUT), 32'd1);
        check("hresp", 32'(bus.HRESP), 32'd0);

        // Register-level vectors
        vecs[0] = '{1'b0, ADDR_STATUS, 32'h0000_000A, 1'b1, 1'b0};
        vecs[1] = '{1'b0, ADDR_CTRL,   32'h0000_0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, ADDR_CMD,    32'h0000_0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, ADDR_CTRL,   32'h0000_0002, 1'b0, 1'b0};
        vecs[4] = '{1'b0, ADDR_CTRL,   32'h0000_0002, 1'b1, 1'b1};
        vecs[5] = '{1'b1, ADDR_CTRL,   32'hFFFF_FFFC, 1'b0, 1'b0};
        vecs[6] = '{1'b0, ADDR_CTRL,   32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, ADDR_DATA,   32'h0000_0000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, ADDR_STATUS, 32'h0000_000A, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) begin
                ahb_write(vecs[i].r, vecs[i].data);
            end else begin
                ahb_read(vecs[i].r, 1'b0, 8'd0, d);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].data);
            end
            if (vecs[i].chk_irq) check($sformatf("vec%0d_irq", i), 32'(IRQ), 32'(vecs[i].exp_irq));
        end

        // TX drain with a 10-cycle frame model
        launched_q.delete();
        ahb_write(ADDR_DATA, 32'h41);
        check("tx_en_before_launch", 32'(TX_EN), 32'd0);
        tick();
        check("tx_en_latency", 32'(TX_EN), 32'd1);
        check("tx_data_launch", 32'(TX_DATA), 32'h41);
        ahb_write(ADDR_DATA, 32'h42);
        ahb_write(ADDR_DATA, 32'h43);
        wait_launches(3, 300);
        ev = 8'h41;
        for (int i = 0; i < launched_q.size(); i++) begin
            check($sformatf("tx_order%0d", i), 32'(launched_q[i]), 32'(ev));
            ev++;
        end
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("tx_drained_status", d, 32'h0000_000A);

        // RX overrun at DEPTH
        for (int i = 0; i <= DEPTH; i++) rx_pulse(8'(i));
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("rx_full_status", d, 32'h0010_0016);
        for (int i = 0; i < DEPTH; i++) begin
            ahb_read(ADDR_DATA, 1'b0, 8'd0, d);
            check($sformatf("rx_read%0d", i), d, 32'(i));
        end
        ahb_read(ADDR_DATA, 1'b0, 8'd0, d);
        check("rx_read_empty", d, 32'd0);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("rx_empty_sticky", d, 32'h0000_001A);
        ahb_write(ADDR_CMD, 32'h1);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("flags_cleared", d, 32'h0000_000A);

        // Push and pop together on a full RX FIFO, then pipelined reads
        for (int i = 0; i < DEPTH; i++) rx_pulse(8'h80 + 8'(i));
        ahb_read(ADDR_DATA, 1'b1, 8'hEE, d);
        check("rx_full_pushpop_data", d, 32'h80);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("rx_full_pushpop_status", d, 32'h0010_0006);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'd0;
        tick();
        d1 = bus.HRDATA;
        tick();
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        d2 = bus.HRDATA;
        tick();
        check("b2b_read0", d1, 32'h81);
        check("b2b_read1", d2, 32'h82);
        ahb_write(ADDR_CMD, 32'h4);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("rx_flushed", d, 32'h0000_000A);

        // RX interrupt timing
        ahb_write(ADDR_CTRL, 32'h1);
        rx_pulse(8'h5A);
        check("irq_at_push", 32'(IRQ), 32'd0);
        tick();
        check("irq_after_push", 32'(IRQ), 32'd1);
        ahb_read(ADDR_DATA, 1'b0, 8'd0, d);
        check("irq_read_data", d, 32'h5A);
        check("irq_at_pop", 32'(IRQ), 32'd1);
        tick();
        check("irq_after_pop", 32'(IRQ), 32'd0);
        ahb_write(ADDR_CTRL, 32'h0);

        // TX overflow with the transmitter stuck busy
        umode = 1;
        tick();
        launched_q.delete();
        for (int i = 0; i < 20; i++) ahb_write(ADDR_DATA, 32'h10 + 32'(i));
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("tx_overflow_status", d, 32'h0000_1029);
        check("tx_overflow_launches", 32'(launched_q.size()), 32'd1);
        ahb_write(ADDR_CMD, 32'h3);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("tx_flush_status", d, 32'h0000_000A);
        ahb_write(ADDR_DATA, 32'h77);
        repeat (20) tick();
        check("wait_done_holds", 32'(launched_q.size()), 32'd1);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("wait_done_count", d, 32'h0000_0108);
        umode = 0;
        wait_launches(2, 100);
        if (launched_q.size() >= 2) check("launch_after_release", 32'(launched_q[1]), 32'h77);

        // Randomized RX traffic against a queue model
        rxm.delete();
        m_ovr = 1'b0;
        for (int s = 0; s < 300; s++) begin
            op = $urandom_range(0, 4);
            b  = 8'($urandom());
            if (op <= 1) begin
                rx_pulse(b);
                if (rxm.size() < DEPTH) rxm.push_back(b); else m_ovr = 1'b1;
            end else begin
                ahb_read(ADDR_DATA, op == 4, b, d);
                ev = (rxm.size() > 0) ? rxm[0] : 8'd0;
                check("rnd_rx_read", d, 32'(ev));
                if (rxm.size() > 0) void'(rxm.pop_front());
                if (op == 4) begin
                    if (rxm.size() < DEPTH) rxm.push_back(b); else m_ovr = 1'b1;
                end
            end
        end
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("rnd_rx_status", d, (32'(rxm.size()) << 16) | (32'(m_ovr) << 4) |
              (32'(rxm.size() == 0) << 3) | (32'(rxm.size() == DEPTH) << 2) | 32'h2);
        ahb_write(ADDR_CMD, 32'h5);

        // Randomized TX bursts: bytes must leave in write order
        repeat (15) tick();
        launched_q.delete();
        txm.delete();
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom());
            ahb_write(ADDR_DATA, {24'd0, b});
            txm.push_back(b);
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_launches(12, 800);
        for (int i = 0; i < launched_q.size() && i < txm.size(); i++)
            check($sformatf("rnd_tx%0d", i), 32'(launched_q[i]), 32'(txm[i]));

        // Asynchronous reset in the middle of a launch
        repeat (15) tick();
        ahb_write(ADDR_CTRL, 32'h3);
        ahb_write(ADDR_DATA, 32'h99);
        tick();
        check("pre_reset_tx_en", 32'(TX_EN), 32'd1);
        #3 HRESET = 1'b1;
        #1;
        check("async_reset_tx_en", 32'(TX_EN), 32'd0);
        check("async_reset_tx_data", 32'(TX_DATA), 32'd0);
        check("async_reset_irq", 32'(IRQ), 32'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        ahb_read(ADDR_CTRL, 1'b0, 8'd0, d);
        check("post_reset_ctrl", d, 32'd0);
        ahb_read(ADDR_STATUS, 1'b0, 8'd0, d);
        check("post_reset_status", d, 32'h0000_000A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
